multdiv_issue: RTL and testbench
================================

# multdiv_issue

Execute-stage issue and writeback controller for the multi-cycle multiply/divide unit. It captures a mult/div instruction from the X stage, holds the operands stable, issues a single-cycle `ctrl_MULT`/`ctrl_DIV` pulse, and stalls the pipeline until `data_resultRDY`. It then delivers one writeback record: the normal result, or an `$rstatus` exception write. It sits between the X-stage decode/bypass logic and `multdiv`, and feeds the X/M pipeline latch.

## Interface
Parameters:
- `TIMEOUT`, 40: cycles in BUSY before forcing completion with exception.
- `RSTATUS_REG`, 30: destination register for exception writes.

Ports:
- `clock`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `op_valid`  in  1  X stage holds a mul/div instruction (held high while stalled).
- `op_is_div`  in  1  1 = div, 0 = mul.
- `op_a`, `op_b`  in  32  bypassed source operands.
- `op_rd`  in  5  destination register.
- `flush`  in  1  squash X stage (branch/jump taken).
- `md_result`  in  32  `multdiv` `data_result`.
- `md_exception`  in  1  `multdiv` `data_exception`.
- `md_ready`  in  1  `multdiv` `data_resultRDY`.
- `ctrl_MULT`, `ctrl_DIV`  out  1  one-cycle start pulses to `multdiv`.
- `md_operandA`, `md_operandB`  out  32  held operands to `multdiv`.
- `stall`  out  1  freeze PC, F/D, D/X.
- `wb_valid`  out  1  writeback record valid (one cycle).
- `wb_rd`  out  5  writeback destination.
- `wb_data`  out  32  writeback value.
- `wb_exception`  out  1  record is an `$rstatus` write.

## Operation
- States: IDLE, START, BUSY, DONE (2-bit).
- IDLE:
  - `op_valid & ~flush` → latch `op_a`, `op_b`, `op_rd`, `op_is_div`; go to START.
  - `stall` = `op_valid & ~flush` (combinational).
- START:
  - Exactly one of `ctrl_MULT`/`ctrl_DIV` = 1, selected by the latched op; `stall`=1.
  - `md_ready` ignored (stale from the previous op); go to BUSY.
- BUSY:
  - `stall`=1; timeout counter increments.
  - `md_ready` → capture `md_result`, `md_exception`; go to DONE.
  - Counter reaches `TIMEOUT-1` without `md_ready` → DONE with exception forced.
- DONE:
  - `wb_valid`=1, `stall`=0; pipeline advances at this edge; go to IDLE.
- Writeback mapping:
  - No exception: `wb_rd`=latched rd, `wb_data`=captured result, `wb_exception`=0.
  - Exception: `wb_rd`=`RSTATUS_REG`, `wb_data`=4 (mul) or 5 (div), `wb_exception`=1.
- Operand hold: `md_operandA`/`md_operandB` are driven from the latch registers and change only on an IDLE accept. `multdiv` relatches its inputs every cycle, so these must stay stable through DONE.
- `flush` in START or BUSY → IDLE next edge, no writeback, counter cleared. `flush` in DONE is ignored because the instruction is retiring. `flush` wins over a simultaneous `op_valid`.
- `op_rd`=0 with no exception → `wb_valid` still 1, `wb_rd`=0; the register file discards the write.

## Timing
- Reset (async): state IDLE; the following outputs are 0: `ctrl_*`, `stall`, `wb_*`, `md_operand*`, counter, latches. Reset mid-operation aborts silently.
- Accept in IDLE at cycle 0 → pulse at cycle 1 → BUSY from cycle 2.
- `md_ready` sampled high at cycle k → `wb_valid` at cycle k+1.
- Total `stall` cycles = k+1 (cycles 0..k).
- Back-to-back ops: the next accept occurs in the IDLE cycle after DONE. That gives a minimum of 1 idle cycle between pulses, which gives `multdiv` time to clear its previous ready.
- `ctrl_MULT` and `ctrl_DIV` are never both high and are never high outside START.

## Structure
- Shared package `multdiv_pkg`:
  - state encoding;
  - `RSTATUS_MUL`=4, `RSTATUS_DIV`=5;
  - `RSTATUS_REG` default;
  - `TIMEOUT` default.
- Sub-module `md_timeout_counter`: 6-bit counter with enable, synchronous clear, async reset, and terminal-count output.
- Operand/rd latches reuse the existing `register32`/`register1` style registers.

## Test plan
- mul 3×7, rd=5; model returns ready at cycle 18 → one `ctrl_MULT` pulse, `stall` high cycles 0–18, then `wb_valid` with rd=5, data=21, exc=0.
- div 100÷7, rd=9 → one `ctrl_DIV` pulse; writeback rd=9, data=14.
- mul 0x40000000×4 with model `md_exception`=1 → rd=30, data=4, `wb_exception`=1.
- div 8÷0 with exception → rd=30, data=5.
- `flush` asserted in the third BUSY cycle → no `wb_valid`, state IDLE, `stall` low next cycle.
- Model never asserts ready → DONE after 40 BUSY cycles with rd=30, data=4.
- Back-to-back mul then div → exactly two pulses, two writebacks in order.
- `reset` pulsed mid-BUSY → all outputs 0 immediately.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
// State encoding, exception codes and default parameters live here.
package multdiv_pkg;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_START = 2'd1,
        MD_BUSY  = 2'd2,
        MD_DONE  = 2'd3
    } md_state_e;

    localparam int          MD_CNT_W           = 6;
    localparam int          MD_TIMEOUT_DEF     = 40;
    localparam int          MD_RSTATUS_REG_DEF = 30;
    localparam logic [31:0] RSTATUS_MUL        = 32'd4;
    localparam logic [31:0] RSTATUS_DIV        = 32'd5;

    typedef struct packed {
        md_state_e             state;
        logic [MD_CNT_W-1:0]   cnt;
    } md_dbg_t;

    function automatic logic [31:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MUL;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Free-running BUSY-cycle counter with enable, synchronous clear and a
// terminal-count flag; clear has priority over enable.
module md_timeout_counter
    import multdiv_pkg::*;
#(
    parameter int TC = MD_TIMEOUT_DEF - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic [MD_CNT_W-1:0] count,
    output logic                tc
);

    localparam logic [MD_CNT_W-1:0] TC_V = MD_CNT_W'(TC);

    logic [MD_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + MD_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign tc    = (cnt_q == TC_V);

endmodule

// File: rtl/multdiv_issue.sv
// X-stage issue/writeback controller for the multi-cycle mult/div unit:
// latches one op, pulses start, stalls until ready or timeout, emits one record.
module multdiv_issue
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT     = MD_TIMEOUT_DEF,
    parameter int RSTATUS_REG = MD_RSTATUS_REG_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    input  logic        op_is_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  op_rd,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output md_dbg_t     dbg
);

    localparam logic [4:0] RSTATUS_RD = 5'(RSTATUS_REG);

    // Handshake: op_valid is held by the X stage for as long as stall is high;
    // the op is consumed at the edge ending the DONE cycle (wb_valid=1, stall=0).
    md_state_e   state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic        div_q, div_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    logic                cnt_en, cnt_clr, cnt_tc;
    logic [MD_CNT_W-1:0] cnt;

    md_timeout_counter #(
        .TC (TIMEOUT - 1)
    ) u_timeout (
        .clk   (clock),
        .rst   (reset),
        .en    (cnt_en),
        .clr   (cnt_clr),
        .count (cnt),
        .tc    (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        div_d   = div_q;
        res_d   = res_q;
        exc_d   = exc_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;

        case (state_q)
            MD_IDLE: begin
                if (op_valid && !flush) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    rd_d    = op_rd;
                    div_d   = op_is_div;
                    state_d = MD_START;
                end
            end
            MD_START: begin
                // md_ready here still belongs to the previous op
                state_d = flush ? MD_IDLE : MD_BUSY;
            end
            MD_BUSY: begin
                if (flush) begin
                    state_d = MD_IDLE;
                end else if (md_ready) begin
                    res_d   = md_result;
                    exc_d   = md_exception;
                    state_d = MD_DONE;
                end else if (cnt_tc) begin
                    res_d   = '0;
                    exc_d   = 1'b1;
                    state_d = MD_DONE;
                end else begin
                    cnt_en  = 1'b1;
                    cnt_clr = 1'b0;
                end
            end
            MD_DONE: begin
                state_d = MD_IDLE;
            end
            default: begin
                state_d = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= MD_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            div_q   <= 1'b0;
            res_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            div_q   <= div_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        ctrl_MULT    = (state_q == MD_START) && !div_q;
        ctrl_DIV     = (state_q == MD_START) && div_q;
        md_operandA  = a_q;
        md_operandB  = b_q;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_rd        = '0;
        wb_data      = '0;
        wb_exception = 1'b0;

        case (state_q)
            MD_IDLE:  stall = op_valid && !flush && !reset;
            MD_START: stall = !reset;
            MD_BUSY:  stall = !reset;
            MD_DONE: begin
                wb_valid     = 1'b1;
                wb_exception = exc_q;
                wb_rd        = exc_q ? RSTATUS_RD : rd_q;
                wb_data      = exc_q ? rstatus_code(div_q) : res_q;
            end
            default: stall = 1'b0;
        endcase

        dbg.state = state_q;
        dbg.cnt   = cnt;
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: driver tasks issue ops and play the
// multdiv model; a negedge monitor checks writebacks against a queue.
module tb_multdiv_issue;
  import multdiv_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        op_is_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [4:0]  op_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0;
  logic        md_ready = 1'b0;
  logic        ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception;
  logic [31:0] md_operandA, md_operandB, wb_data;
  logic [4:0]  wb_rd;
  md_dbg_t     dbg;

  int total = 0;
  int bad = 0;
  int mult_pulses = 0;
  int div_pulses = 0;
  logic [37:0] exp_q[$];

  // clock / reset
  always #5 clock = ~clock;

  multdiv_issue dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_is_div    (op_is_div),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_rd        (op_rd),
    .flush        (flush),
    .md_result    (md_result),
    .md_exception (md_exception),
    .md_ready     (md_ready),
    .ctrl_MULT    (ctrl_MULT),
    .ctrl_DIV     (ctrl_DIV),
    .md_operandA  (md_operandA),
    .md_operandB  (md_operandB),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exception (wb_exception),
    .dbg          (dbg)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, want);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [37:0] exp;
    if (wb_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected got rd=%0d data=%0h exc=%0b required no writeback",
                 wb_rd, wb_data, wb_exception);
      end else begin
        exp = exp_q.pop_front();
        if ({wb_rd, wb_data, wb_exception} !== exp) begin
          bad++;
          $display("FAIL wb_record got rd=%0d data=%0h exc=%0b required rd=%0d data=%0h exc=%0b",
                   wb_rd, wb_data, wb_exception, exp[37:33], exp[32:1], exp[0]);
        end
      end
    end
    if (ctrl_MULT || ctrl_DIV) begin
      total++;
      if ((ctrl_MULT && ctrl_DIV) || dbg.state != MD_START) begin
        bad++;
        $display("FAIL ctrl_pulse got mult=%0b div=%0b state=%0d required single pulse in START",
                 ctrl_MULT, ctrl_DIV, dbg.state);
      end
      mult_pulses += int'(ctrl_MULT);
      div_pulses  += int'(ctrl_DIV);
    end
  end

  // driver: call at posedge+1; cycle 0 is the IDLE cycle presenting the op
  task automatic run_op(input string name, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input int rdy_cyc,
                        input logic [31:0] res, input logic exc, input int flush_cyc,
                        input int exp_stall, input int exp_wb_cyc,
                        input logic push, input logic [37:0] exp_rec);
    int stall_cnt = 0;
    int wb_cyc = -1;
    int m0 = mult_pulses;
    int d0 = div_pulses;
    int op_checks = 0;
    logic op_ok = 1'b1;
    logic accepted = (flush_cyc != 0);
    if (push) exp_q.push_back(exp_rec);
    op_valid = 1'b1; op_is_div = is_div; op_a = a; op_b = b; op_rd = rd;
    for (int c = 0; c < 100; c++) begin
      md_ready     = (c == rdy_cyc);
      md_result    = (c == rdy_cyc) ? res : 32'hdead_beef;
      md_exception = (c == rdy_cyc) && exc;
      flush        = (c == flush_cyc);
      @(negedge clock);
      if (stall) stall_cnt++;
      if (c >= 1) begin
        op_checks++;
        if (md_operandA !== a || md_operandB !== b) op_ok = 1'b0;
      end
      if (wb_valid) wb_cyc = c;
      @(posedge clock); #1;
      if (wb_cyc >= 0 || c == flush_cyc) break;
    end
    md_ready = 1'b0; md_exception = 1'b0; flush = 1'b0;
    check({name, ".stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
    check({name, ".wb_cycle"}, 64'(wb_cyc), 64'(exp_wb_cyc));
    check({name, ".mult_pulses"}, 64'(mult_pulses - m0), 64'(accepted && !is_div));
    check({name, ".div_pulses"}, 64'(div_pulses - d0), 64'(accepted && is_div));
    if (op_checks > 0) check({name, ".operand_hold"}, 64'(op_ok), 64'd1);
  endtask

  task automatic idle(input int n);
    op_valid = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #12;
    check("reset.outputs", {ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception, wb_rd, wb_data,
                            md_operandA, md_operandB} == '0, 1'b1);
    check("reset.dbg", 64'(dbg), 64'({MD_IDLE, 6'd0}));
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    run_op("mul3x7", 1'b0, 32'd3, 32'd7, 5'd5, 18, 32'd21, 1'b0, -1, 19, 19,
           1'b1, {5'd5, 32'd21, 1'b0});
    idle(2);
    // flush in DONE must be ignored
    run_op("div100_7", 1'b1, 32'd100, 32'd7, 5'd9, 10, 32'd14, 1'b0, 11, 11, 11,
           1'b1, {5'd9, 32'd14, 1'b0});
    idle(2);
    run_op("mul_ovf", 1'b0, 32'h4000_0000, 32'd4, 5'd12, 6, 32'd0, 1'b1, -1, 7, 7,
           1'b1, {5'd30, 32'd4, 1'b1});
    idle(2);
    run_op("div8_0", 1'b1, 32'd8, 32'd0, 5'd7, 5, 32'd0, 1'b1, -1, 6, 6,
           1'b1, {5'd30, 32'd5, 1'b1});
    idle(2);

    run_op("flush_busy", 1'b0, 32'd9, 32'd9, 5'd3, -1, 32'd0, 1'b0, 4, 5, -1,
           1'b0, '0);
    op_valid = 1'b0;
    @(negedge clock);
    check("flush_busy.stall_after", 64'(stall), 64'd0);
    check("flush_busy.dbg_after", 64'(dbg), 64'({MD_IDLE, 6'd0}));
    @(posedge clock); #1;
    idle(3);

    run_op("flush_idle", 1'b1, 32'd50, 32'd5, 5'd8, -1, 32'd0, 1'b0, 0, 0, -1,
           1'b0, '0);
    idle(3);

    // ready in START is stale; nothing else arrives, so the timeout fires
    run_op("timeout", 1'b0, 32'd1, 32'd1, 5'd6, 1, 32'h77, 1'b0, -1, 42, 42,
           1'b1, {5'd30, 32'd4, 1'b1});
    idle(2);

    run_op("b2b_mul", 1'b0, 32'd2, 32'd5, 5'd3, 4, 32'd10, 1'b0, -1, 5, 5,
           1'b1, {5'd3, 32'd10, 1'b0});
    run_op("b2b_div", 1'b1, 32'd9, 32'd3, 5'd4, 4, 32'd3, 1'b0, -1, 5, 5,
           1'b1, {5'd4, 32'd3, 1'b0});
    idle(2);

    run_op("rd0", 1'b0, 32'd6, 32'd6, 5'd0, 3, 32'd36, 1'b0, -1, 4, 4,
           1'b1, {5'd0, 32'd36, 1'b0});
    idle(2);

    // asynchronous reset in the middle of BUSY
    op_valid = 1'b1; op_is_div = 1'b0; op_a = 32'd5; op_b = 32'd5; op_rd = 5'd2;
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("pre_reset.busy", 64'(dbg.state), 64'(MD_BUSY));
    #2 reset = 1'b1;
    #1;
    check("midreset.outputs", {ctrl_MULT, ctrl_DIV, stall, wb_valid, wb_exception, wb_rd, wb_data,
                               md_operandA, md_operandB} == '0, 1'b1);
    check("midreset.dbg", 64'(dbg), 64'({MD_IDLE, 6'd0}));
    @(posedge clock); #1;
    op_valid = 1'b0;
    reset = 1'b0;
    idle(4);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
